// File: rtl/ntt_output_unloader_if.sv
// Bundle between the unloader, the coefficient BRAM bank read ports and the
// downstream consumer of packed 192-bit words.
interface ntt_output_unloader_if #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_BANKS    = 8,
    parameter int OUTPUT_WIDTH = 192
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic                    re;
    logic [BANK_W-1:0]       rd_bank;
    logic [ADDR_WIDTH-1:0]   addr_rd_a;
    logic [ADDR_WIDTH-1:0]   addr_rd_b;
    logic [DATA_WIDTH-1:0]   rdata_a;
    logic [DATA_WIDTH-1:0]   rdata_b;
    logic [OUTPUT_WIDTH-1:0] dout;
    logic                    dout_valid;
    logic                    dout_ready;

    // Unloader side.
    modport master (
        output re, rd_bank, addr_rd_a, addr_rd_b, dout, dout_valid,
        input  rdata_a, rdata_b, dout_ready
    );

    // Banks plus consumer side.
    modport slave (
        input  re, rd_bank, addr_rd_a, addr_rd_b, dout, dout_valid,
        output rdata_a, rdata_b, dout_ready
    );
endinterface

// File: rtl/ntt_output_unloader.sv
// Reads the 256 coefficients back out of the eight BRAM banks (two per cycle
// through the dual read ports), packs them 16 per 192-bit word with the first
// coefficient in the MSBs, and streams the words out over valid/ready.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; no reads in flight
// ISSUE  | one bank read per cycle, word_cnt/pair_cnt name the next read
// WAIT   | holding at a word boundary until fewer than 2 words are buffered
// FINISH | all 128 reads issued; waiting for the 16th handshake, then done
module ntt_output_unloader #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_BANKS    = 8,
    parameter int OUTPUT_WIDTH = 192,
    parameter int READ_LATE    = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    output logic busy,
    output logic done,
    ntt_output_unloader_if.master bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int PAIRS  = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t                  state_q;
    logic [3:0]              word_cnt;
    logic [2:0]              pair_cnt;
    logic [1:0]              occ_q;
    logic [3:0]              hs_cnt;
    logic                    busy_q;
    logic                    done_q;

    logic                    re_q;
    logic [BANK_W-1:0]       rd_bank_q;
    logic [ADDR_WIDTH-1:0]   addr_a_q;
    logic [ADDR_WIDTH-1:0]   addr_b_q;
    logic [2:0]              rd_pair_q;

    logic [READ_LATE-1:0]    pipe_v;
    logic [2:0]              pipe_p [READ_LATE];

    logic [OUTPUT_WIDTH-1:0] asm_q;
    logic [OUTPUT_WIDTH-1:0] asm_next;
    logic                    asm_full_q;
    logic [OUTPUT_WIDTH-1:0] dout_q;
    logic                    dout_valid_q;

    logic                    hs;
    logic [1:0]              occ_eff;
    logic                    start_ok;
    logic                    issue;
    logic [3:0]              issue_word;
    logic [2:0]              issue_pair;
    logic                    new_word;
    logic                    cap_v;
    logic [2:0]              cap_pair;
    logic                    word_done;
    logic                    load_direct;

    assign bus.re         = re_q;
    assign bus.rd_bank    = rd_bank_q;
    assign bus.addr_rd_a  = addr_a_q;
    assign bus.addr_rd_b  = addr_b_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

    // Issue decision: a word boundary needs a free storage slot, counting a
    // handshake on this edge as already freeing one.
    always_comb begin
        hs         = dout_valid_q && bus.dout_ready;
        occ_eff    = occ_q - {1'b0, hs};
        start_ok   = (state_q == IDLE) && start && !done_q;
        issue      = 1'b0;
        issue_word = word_cnt;
        issue_pair = pair_cnt;
        if (start_ok) begin
            issue      = 1'b1;
            issue_word = 4'd0;
            issue_pair = 3'd0;
        end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
            issue = (pair_cnt != 3'd0) || (occ_eff < 2'd2);
        end
        new_word = issue && (issue_pair == 3'd0);
    end

    // Return-path capture: place the returning pair into its slot of the word.
    always_comb begin
        cap_v       = pipe_v[READ_LATE-1];
        cap_pair    = pipe_p[READ_LATE-1];
        word_done   = cap_v && (cap_pair == 3'd7);
        load_direct = word_done && (!dout_valid_q || hs);
        asm_next    = asm_q;
        for (int p = 0; p < PAIRS; p++) begin
            if (cap_v && (cap_pair == 3'(p))) begin
                asm_next[OUTPUT_WIDTH-1-2*DATA_WIDTH*p -: DATA_WIDTH]          = bus.rdata_a;
                asm_next[OUTPUT_WIDTH-1-DATA_WIDTH-2*DATA_WIDTH*p -: DATA_WIDTH] = bus.rdata_b;
            end
        end
    end

    // Issue FSM with registered read-port outputs, busy and done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            word_cnt  <= 4'd0;
            pair_cnt  <= 3'd0;
            hs_cnt    <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            re_q      <= 1'b0;
            rd_bank_q <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            rd_pair_q <= 3'd0;
        end else begin
            re_q   <= issue;
            done_q <= 1'b0;
            if (issue) begin
                rd_bank_q <= issue_word[3:1];
                addr_a_q  <= {issue_word[0], issue_pair, 1'b0};
                addr_b_q  <= {issue_word[0], issue_pair, 1'b1};
                rd_pair_q <= issue_pair;
                pair_cnt  <= issue_pair + 3'd1;
                word_cnt  <= (issue_pair == 3'd7) ? issue_word + 4'd1 : issue_word;
            end
            if (hs) begin
                hs_cnt <= hs_cnt + 4'd1;
            end
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        hs_cnt  <= 4'd0;
                    end
                end
                ISSUE, WAIT: begin
                    if (issue && (issue_word == 4'd15) && (issue_pair == 3'd7)) begin
                        state_q <= FINISH;
                    end else if (issue) begin
                        state_q <= ISSUE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                FINISH: begin
                    if (hs && (hs_cnt == 4'd15)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Words issued but not yet handed to the consumer (at most 2).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_q + {1'b0, new_word} - {1'b0, hs};
        end
    end

    // Read-latency pipeline tagging each read with its pair index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_v <= '0;
            for (int i = 0; i < READ_LATE; i++) begin
                pipe_p[i] <= 3'd0;
            end
        end else begin
            pipe_v[0] <= re_q;
            pipe_p[0] <= rd_pair_q;
            for (int i = 1; i < READ_LATE; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_p[i] <= pipe_p[i-1];
            end
        end
    end

    // Assembly register and output register; a completed word skips the
    // assembly stage when dout is free on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            asm_q        <= '0;
            asm_full_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            if (cap_v) begin
                asm_q <= asm_next;
            end
            if (load_direct) begin
                dout_q       <= asm_next;
                dout_valid_q <= 1'b1;
            end else if (hs && asm_full_q) begin
                dout_q       <= asm_q;
                dout_valid_q <= 1'b1;
                asm_full_q   <= 1'b0;
            end else if (hs) begin
                dout_valid_q <= 1'b0;
            end
            if (word_done && !load_direct) begin
                asm_full_q <= 1'b1;
            end
        end
    end
endmodule

// File: doc/ntt_output_unloader.md
# ntt_output_unloader

Downstream stage of the NTT/INTT controller. When the controller signals that transform processing is complete, this block reads all 256 coefficients back out of the eight coefficient BRAM banks. Reads use the banks' dual read ports, two coefficients per cycle. The coefficients are packed into 192-bit words of 16 × 12-bit coefficients, and the words are streamed out under a valid/ready handshake. It is the mirror of the load path: word packing matches the 192-bit input format, first coefficient in the MSBs.

## Interface
- DATA_WIDTH, 12, coefficient width
- ADDR_WIDTH, 5, per-bank address width (32 entries/bank)
- NUM_BANKS, 8, coefficient BRAM banks
- OUTPUT_WIDTH, 192, packed word width (16 coefficients)
- READ_LATE, 2, cycles from `re` asserted to `rdata_a/b` valid (1..7)
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse (driven from controller `done_all`); ignored while `busy`
- `re` out 1: bank read enable
- `rd_bank` out 3: bank selected for current read
- `addr_rd_a`, `addr_rd_b` out ADDR_WIDTH: port A/B read addresses
- `rdata_a`, `rdata_b` in DATA_WIDTH: bank read data, from the bank selected at issue, READ_LATE cycles after `re`
- `dout` out OUTPUT_WIDTH: packed output word
- `dout_valid` out 1: `dout` holds a word
- `dout_ready` in 1: consumer accepts; transfer when `dout_valid && dout_ready`
- `busy` out 1: unload in progress
- `done` out 1: one-cycle pulse after last word transferred

## Operation
- Reset: `re`, `dout_valid`, `busy`, `done` = 0. `rd_bank`, `addr_rd_a`, `addr_rd_b`, `dout` = 0. All counters and occupancy are cleared, and the issue FSM goes to IDLE. A reset mid-unload discards all partial data; no `done` is produced.
- Issue FSM states: IDLE, ISSUE, WAIT, FINISH.
  - IDLE: `start` moves the FSM to ISSUE, sets `busy`, and clears word_cnt (4b) and pair_cnt (3b).
  - ISSUE: one read per cycle, 8 reads per word k. Each read drives `re`=1, `rd_bank`=k[3:1], `addr_rd_a`={k[0], pair, 0} and `addr_rd_b`={k[0], pair, 1}. After pair 7, word_cnt increments. After word 15, go to FINISH.
  - Issue credit: a new word (pair 0) starts only if occupancy < 2. Otherwise go to WAIT with `re`=0, and return to ISSUE when occupancy < 2.
  - Occupancy: +1 at a word's pair-0 issue, −1 on a handshake. Storage is one assembly register plus the `dout` register.
  - FINISH: wait for the 16th handshake, then pulse `done`, clear `busy`, and return to IDLE.
- Return path: a READ_LATE-deep valid/position pipeline tags each read with its pair index.
  - Pair p of a word: `rdata_a` goes to bits [191−24p -: 12] and `rdata_b` to bits [179−24p -: 12] of the assembly register.
  - On capture of pair 7, the word is complete. If `dout` is empty or is handshaking in that cycle, the completed word (including the pair-7 data) loads directly into `dout` on that edge and `dout_valid` is set. Otherwise it is held in the assembly register and moves to `dout` on the edge of the next handshake.
- Handshake: `dout` and `dout_valid` stay stable while `dout_valid && !dout_ready`. `dout_valid` deasserts after a handshake unless a new word loads on the same edge.
- `start` while `busy`: ignored. `start` coinciding with the `done` pulse: ignored.

## Timing
- Let E0 be the edge sampling `start`. `re` is high for the 8 cycles following E0, pairs 0..7 of word 0.
- With `dout_ready`=1, the first `dout_valid` is asserted after edge E(8+READ_LATE).
- Sustained throughput: one word per 8 cycles; `re` is continuously high for 128 cycles.
- `done` is high in the cycle after the 16th handshake edge.
- Minimum start-to-done with `dout_ready`=1: 129+READ_LATE cycles.
- Backpressure: at most 2 words are buffered. Issue stalls at pair-0 boundaries only; a word is never split across a stall.

## Test plan
- Banks preloaded with value = bank*32+addr, `dout_ready`=1, start pulse:
  - 16 words are produced; word 0 = coefficients 0..15 MSB-first, word 15 = coefficients 240..255.
  - `done` pulses once, 129+READ_LATE cycles after `start`.
- Address sweep: check `rd_bank`/`addr_rd_a`/`addr_rd_b` over the 128 reads. For word 3, pair 5: bank 1, addresses 26 and 27.
- `dout_ready`=0 for 40 cycles after start:
  - `re` stops after 16 reads; occupancy is 2, and `dout` holds word 0 stable.
  - On release, words 0..15 arrive in order with no loss or duplication.
- Random `dout_ready` (50%) with READ_LATE=1 and READ_LATE=4: output matches the golden stream, and `dout` is stable whenever stalled.
- `start` pulsed again mid-unload and on the `done` cycle: both are ignored and no second `done` appears.
- `rst_i` at word 7: all outputs return to reset values next cycle. A fresh `start` then produces the full 16-word stream from word 0.
